lut_ram_wr_arbiter: RTL and testbench
=====================================

LUT_RAM_WR_ARBITER -- requirements
Module: lut_ram_wr_arbiter

Interface
REQ-001 Parameter LUT_WIDTH, default XLEN (32): data width of the lut_ram being controlled.
REQ-002 Parameter LUT_DEPTH, default 1000: number of lut_ram entries; AW = $clog2(LUT_DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 a_valid / b_valid  input  1  write request from client A / B.
REQ-006 a_ready / b_ready  output  1  request accepted this cycle (combinational).
REQ-007 a_addr / b_addr  input  AW  client write address.
REQ-008 a_data / b_data  input  LUT_WIDTH  client write data.
REQ-009 clr_start  input  1  one-cycle pulse; request zero-fill of the whole RAM.
REQ-010 busy  output  1  high while clear sequence runs.
REQ-011 clr_done  output  1  registered one-cycle pulse after the last clear write.
REQ-012 oob_err  output  1  registered one-cycle pulse after an accepted out-of-range request.
REQ-013 ram_wr_en / ram_wr_addr / ram_wr_data  output  1 / AW / LUT_WIDTH  drive lut_ram write port directly.

Function
REQ-014 States: IDLE, CLEAR; reset state IDLE.
REQ-015 IDLE, clr_start=1: enter CLEAR next cycle; no grant issued that cycle even if a_valid/b_valid high.
REQ-016 IDLE, clr_start=0: arbitrate; a_ready/b_ready combinational from valids and priority pointer.
REQ-017 Only one valid high: that client granted.
REQ-018 Both valid: client named by priority pointer granted; other ready=0.
REQ-019 Priority pointer: 1-bit register, reset to A; after any grant, points to the non-granted client (round-robin).
REQ-020 Granted, addr < LUT_DEPTH: ram_wr_en=1, ram_wr_addr/ram_wr_data = granted client's addr/data, same cycle; write lands at next clk edge.
REQ-021 Granted, addr >= LUT_DEPTH: ready=1 (request consumed), ram_wr_en=0, oob_err=1 next cycle for one cycle; pointer still rotates.
REQ-022 No grant: ram_wr_en=0; ram_wr_addr/ram_wr_data = 0.
REQ-023 Ready is never asserted without the matching valid; at most one ready high per cycle.
REQ-024 CLEAR: counter starts at 0; each cycle ram_wr_en=1, ram_wr_addr=counter, ram_wr_data=0; counter increments.
REQ-025 CLEAR: a_ready=b_ready=0 regardless of valids; busy=1.
REQ-026 CLEAR, counter == LUT_DEPTH-1: write final entry, return to IDLE next cycle, clr_done=1 in that next cycle; counter reset to 0.
REQ-027 Clear takes exactly LUT_DEPTH cycles with busy=1; clr_start during CLEAR ignored (no restart, no extension).
REQ-028 Pointer not modified during CLEAR.
REQ-029 Counter never exceeds LUT_DEPTH-1; no wrap past last entry.

Reset
REQ-030 rst=1 at a clock edge: state IDLE, counter 0, pointer A, clr_done=0, oob_err=0.
REQ-031 While rst=1: a_ready=b_ready=0, ram_wr_en=0, busy=0.
REQ-032 Reset mid-CLEAR aborts the clear; no clr_done pulse; partially cleared entries remain cleared.

Verification
REQ-033 Single-client: a_valid=1, a_addr=5, a_data=0xDEADBEEF, b_valid=0 -> a_ready=1, ram_wr_en=1 same cycle; lut_ram rd_addr=5 reads 0xDEADBEEF after next edge.
REQ-034 Contention: both valid continuously for 4 cycles after reset, distinct addrs -> grants A,B,A,B; exactly one ready per cycle; lut_ram contents match reference model.
REQ-035 Clear: fill addrs 0, 500, 999 with nonzero, pulse clr_start -> busy=1 for 1000 cycles, ready=0 throughout, clr_done one pulse, all three addrs read 0.
REQ-036 Out-of-range: b_valid=1, b_addr=1000 -> b_ready=1, ram_wr_en=0, oob_err=1 next cycle only; RAM unchanged.
REQ-037 Simultaneous: clr_start=1 with a_valid=1 in IDLE -> a_ready=0 that cycle; A served after clr_done.
REQ-038 Reset mid-clear at counter=300 -> busy=0 after edge, no clr_done, next a request granted normally with pointer at A.

Source files
------------

// File: rtl/lut_ram_wr_arbiter_if.sv
// Write-port bundle between two write clients, the clear controller and the
// lut_ram write port.
//   a_*/b_*     : client write requests (valid/addr/data in, ready out)
//   clr_start   : zero-fill request pulse
//   busy        : clear sequence in progress
//   clr_done    : one-cycle pulse after the final clear write
//   oob_err     : one-cycle pulse after an accepted out-of-range request
//   ram_wr_*    : lut_ram write port
interface lut_ram_wr_arbiter_if #(
  parameter int LUT_WIDTH = 32,
  parameter int LUT_DEPTH = 1000
);
  localparam int AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

  logic                 a_valid;
  logic                 a_ready;
  logic [AW-1:0]        a_addr;
  logic [LUT_WIDTH-1:0] a_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [AW-1:0]        b_addr;
  logic [LUT_WIDTH-1:0] b_data;
  logic                 clr_start;
  logic                 busy;
  logic                 clr_done;
  logic                 oob_err;
  logic                 ram_wr_en;
  logic [AW-1:0]        ram_wr_addr;
  logic [LUT_WIDTH-1:0] ram_wr_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_start,
    input  a_ready, b_ready, busy, clr_done, oob_err,
           ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_start,
    output a_ready, b_ready, busy, clr_done, oob_err,
           ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/lut_ram_wr_arbiter.sv
// Round-robin write arbiter for a lut_ram with two clients and a built-in
// zero-fill sequencer.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lut_ram_wr_arbiter_if.slave (client requests, status, RAM write port)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | arbitrate client writes, watch for clr_start
// CLEAR  | write zero to every entry, one per cycle, clients held off
module lut_ram_wr_arbiter #(
  parameter int LUT_WIDTH = 32,
  parameter int LUT_DEPTH = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  lut_ram_wr_arbiter_if.slave  bus
);
  localparam int AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(LUT_DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(LUT_DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          ptr_q;        // 0: A has priority, 1: B has priority
  logic          clr_done_q;
  logic          oob_err_q;

  logic                 arb_en;
  logic                 gnt_a;
  logic                 gnt_b;
  logic                 gnt_any;
  logic                 gnt_oob;
  logic [AW-1:0]        gnt_addr;
  logic [LUT_WIDTH-1:0] gnt_data;
  logic                 clearing;
  logic                 cnt_last;

  always_comb begin
    // A clr_start in IDLE takes the cycle; no client is granted alongside it.
    arb_en   = !rst && (state_q == S_IDLE) && !bus.clr_start;
    gnt_a    = arb_en && bus.a_valid && (!bus.b_valid || !ptr_q);
    gnt_b    = arb_en && bus.b_valid && (!bus.a_valid ||  ptr_q);
    gnt_any  = gnt_a || gnt_b;
    gnt_addr = gnt_a ? bus.a_addr : bus.b_addr;
    gnt_data = gnt_a ? bus.a_data : bus.b_data;
    gnt_oob  = {1'b0, gnt_addr} >= DEPTH_EXT;
    clearing = !rst && (state_q == S_CLEAR);
    cnt_last = (cnt_q == LAST_IDX);
  end

  always_comb begin
    bus.a_ready     = gnt_a;
    bus.b_ready     = gnt_b;
    bus.busy        = clearing;
    bus.clr_done    = clr_done_q;
    bus.oob_err     = oob_err_q;
    bus.ram_wr_en   = 1'b0;
    bus.ram_wr_addr = '0;
    bus.ram_wr_data = '0;
    if (clearing) begin
      bus.ram_wr_en   = 1'b1;
      bus.ram_wr_addr = cnt_q;
    end else if (gnt_any && !gnt_oob) begin
      bus.ram_wr_en   = 1'b1;
      bus.ram_wr_addr = gnt_addr;
      bus.ram_wr_data = gnt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      clr_done_q <= 1'b0;
      oob_err_q  <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      oob_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.clr_start) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
          end else if (gnt_any) begin
            // Out-of-range requests are consumed and still rotate priority.
            ptr_q     <= gnt_a;
            oob_err_q <= gnt_oob;
          end
        end
        S_CLEAR: begin
          if (cnt_last) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_ram_wr_arbiter.sv
module tb_lut_ram_wr_arbiter;
  localparam int W     = 32;
  localparam int DEPTH = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_ram_wr_arbiter_if #(.LUT_WIDTH(W), .LUT_DEPTH(DEPTH)) bus ();

  lut_ram_wr_arbiter #(.LUT_WIDTH(W), .LUT_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // lut_ram being driven by the arbiter
  logic [W-1:0] ram [0:DEPTH-1];
  always @(posedge clk)
    if (bus.ram_wr_en && (int'(bus.ram_wr_addr) < DEPTH))
      ram[bus.ram_wr_addr] <= bus.ram_wr_data;

  // reference model
  logic [W-1:0] ref_mem [0:DEPTH-1];
  bit m_ptr, m_clear, m_oob, m_done;
  int m_cnt;

  typedef struct {
    bit           ar;
    bit           br;
    bit           en;
    logic [9:0]   addr;
    logic [W-1:0] data;
    bit           busy;
    bit           oob;
    bit           done;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int busy_seen, done_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit av, input int aa, input logic [W-1:0] ad,
                      input bit bv, input int ba, input logic [W-1:0] bd,
                      input bit clr);
    exp_t e, g;
    bit ga, gb, nxt_oob, nxt_done;
    int agr;
    bus.a_valid = av; bus.a_addr = aa[9:0]; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba[9:0]; bus.b_data = bd;
    bus.clr_start = clr;
    e = '{default: 0};
    e.busy = m_clear; e.oob = m_oob; e.done = m_done;
    nxt_oob = 0; nxt_done = 0;
    if (m_clear) begin
      e.en = 1; e.addr = m_cnt[9:0]; e.data = '0;
    end else if (!clr) begin
      ga = av && (!bv || !m_ptr);
      gb = bv && (!av || m_ptr);
      if (ga || gb) begin
        agr = ga ? aa : ba;
        e.ar = ga; e.br = gb;
        if (agr < DEPTH) begin
          e.en = 1; e.addr = agr[9:0]; e.data = ga ? ad : bd;
        end else nxt_oob = 1;
        m_ptr = ga;
      end
    end
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk("a_ready", bus.a_ready, g.ar);
    chk("b_ready", bus.b_ready, g.br);
    chk("wr_en",   bus.ram_wr_en, g.en);
    chk("wr_addr", bus.ram_wr_addr, g.en ? g.addr : 10'd0);
    chk("wr_data", bus.ram_wr_data, g.en ? g.data : '0);
    chk("busy",    bus.busy, g.busy);
    chk("oob_err", bus.oob_err, g.oob);
    chk("clr_done", bus.clr_done, g.done);
    busy_seen += int'(bus.busy);
    done_seen += int'(bus.clr_done);
    @(posedge clk); #1;
    if (g.en) ref_mem[g.addr] = g.data;
    if (m_clear) begin
      if (m_cnt == DEPTH-1) begin m_clear = 0; m_cnt = 0; nxt_done = 1; end
      else m_cnt++;
    end else if (clr) begin
      m_clear = 1; m_cnt = 0;
    end
    m_oob = nxt_oob; m_done = nxt_done;
  endtask

  task automatic idle_step();
    step(0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.a_valid = 1; bus.a_addr = 10'd3; bus.a_data = 32'h1;
    bus.b_valid = 1; bus.b_addr = 10'd4; bus.b_data = 32'h2;
    bus.clr_start = 0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_a_ready", bus.a_ready, 1'b0);
      chk("rst_b_ready", bus.b_ready, 1'b0);
      chk("rst_wr_en",   bus.ram_wr_en, 1'b0);
      chk("rst_busy",    bus.busy, 1'b0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    m_ptr = 0; m_clear = 0; m_cnt = 0; m_oob = 0; m_done = 0;
    sb.delete();
  endtask

  task automatic chk_mem(input string tag, input int addr);
    chk(tag, ram[addr], ref_mem[addr]);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    bus.a_valid = 0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_addr = '0; bus.b_data = '0;
    bus.clr_start = 0;
    @(posedge clk); #1;
    do_reset(2);

    // single client write
    step(1, 5, 32'hDEADBEEF, 0, 0, '0, 0);
    idle_step();
    chk("ram5", ram[5], 32'hDEADBEEF);

    // contention after reset: A,B,A,B
    do_reset(1);
    for (int i = 0; i < 4; i++)
      step(1, 10 + i, 32'hA000 + i, 1, 20 + i, 32'hB000 + i, 0);
    idle_step();
    for (int i = 0; i < 4; i++) begin
      chk_mem("cont_a", 10 + i);
      chk_mem("cont_b", 20 + i);
    end

    // out-of-range on B; oob_err checked by the following two steps
    step(0, 0, '0, 1, 1000, 32'h5555, 0);
    idle_step();
    idle_step();
    chk_mem("oob_ram0", 0);

    // clear with simultaneous A request, held through the clear
    step(1, 0,   32'h11, 0, 0, '0, 0);
    step(1, 500, 32'h22, 0, 0, '0, 0);
    step(1, 999, 32'h33, 0, 0, '0, 0);
    chk("pre0",   ram[0],   32'h11);
    chk("pre500", ram[500], 32'h22);
    busy_seen = 0; done_seen = 0;
    step(1, 7, 32'h77, 0, 0, '0, 1);
    guard = 0;
    while (m_clear && guard < 1100) begin
      step(1, 7, 32'h77, 0, 0, '0, (m_cnt == 500));
      guard++;
    end
    step(1, 7, 32'h77, 0, 0, '0, 0);   // clr_done cycle, A served
    idle_step();
    chk("clr_len",   busy_seen, 1000);
    chk("clr_pulses", done_seen, 1);
    chk("clr0",   ram[0],   '0);
    chk("clr500", ram[500], '0);
    chk("clr999", ram[999], '0);
    chk("after_clr7", ram[7], 32'h77);

    // reset mid-clear at counter 300
    step(1, 100, 32'h100, 0, 0, '0, 0);
    step(1, 700, 32'h700, 0, 0, '0, 0);
    step(0, 0, '0, 1, 33, 32'h33, 0);   // leaves pointer at A anyway
    step(0, 0, '0, 0, 0, '0, 1);
    while (m_clear && m_cnt < 300) idle_step();
    chk("abort_cnt", m_cnt, 300);
    do_reset(1);
    done_seen = 0;
    step(1, 40, 32'h4040, 1, 41, 32'h4141, 0);
    idle_step();
    chk("abort_done", done_seen, 0);
    chk("abort100", ram[100], '0);
    chk("abort299", ram[299], '0);
    chk("abort700", ram[700], 32'h700);
    chk("abort40",  ram[40],  32'h4040);

    // random traffic
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1023), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1023), $urandom, 0);
    idle_step();
    for (int i = 0; i < DEPTH; i++) chk_mem("final_mem", i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
